// File: rtl/keypad_encoder.sv
// keypad_encoder: microwave keypad front end.
// Synchronises 12 raw, bouncing button lines, debounces both press and
// release, and emits exactly one single-cycle pulse per accepted press as
// both a one-hot vector (key_pulse) and a binary index (key_code).
// Index 0-9 are digits, 10 is "inicia", 11 is "cancela".

// keypad_sync_bit: two-flop synchroniser for one raw button line.
module keypad_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is ever used by downstream logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// keypad_encoder: per-key synchronisers feeding one shared debounce FSM.
module keypad_encoder #(
  parameter int DB_CYC = 16,   // cycles a level must be stable to be accepted
  parameter int CNT_W  = 16    // debounce counter width, 2**CNT_W > DB_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_raw,
  output logic [11:0] key_pulse,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        busy
);

  localparam int NUM_KEYS = 12;
  localparam int IDX_W    = 4;

  // Last count value before acceptance; cnt never goes beyond this.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] REL_DB   = 2'd3;

  // Everything the FSM carries from cycle to cycle.
  typedef struct packed {
    logic [1:0]       st;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
  } fsm_t;

  logic [NUM_KEYS-1:0] ks;        // synchronised key levels
  fsm_t                fsm_q;
  fsm_t                fsm_d;
  logic                accept;    // debounce of a press completes this cycle
  logic                ks_zero;
  logic                ks_onehot;
  logic [IDX_W-1:0]    ks_idx;
  logic [NUM_KEYS-1:0] idx_mask;  // one-hot of the captured key

  // ---------------------------------------------------------------------------
  // Per-key synchronisers
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_sync
    keypad_sync_bit u_sync (
      .clk (clk),
      .rst (rst),
      .d   (key_raw[i]),
      .q   (ks[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Key vector decode
  // ---------------------------------------------------------------------------

  // Binary index of a one-hot vector. Bits are OR-ed rather than
  // priority-encoded: the result is only used when exactly one bit is set,
  // so no key is ever favoured over another.
  function automatic logic [IDX_W-1:0] enc_onehot(input logic [NUM_KEYS-1:0] v);
    logic [IDX_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) code = code | IDX_W'(i);
    end
    return code;
  endfunction

  // Classify the synchronised key vector: none, exactly one, or several.
  always_comb begin
    ks_zero   = (ks == '0);
    ks_onehot = !ks_zero && ((ks & (ks - NUM_KEYS'(1))) == '0);
    ks_idx    = enc_onehot(ks);
    idx_mask  = NUM_KEYS'(1) << fsm_q.idx;
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------

  // Next-state logic. cnt is cleared on every state entry and stops at
  // CNT_LAST, where the state always changes, so it can never wrap.
  always_comb begin
    fsm_d  = fsm_q;
    accept = 1'b0;
    case (fsm_q.st)
      IDLE: begin
        // Two or more keys together are ignored outright.
        if (ks_onehot) begin
          fsm_d.st  = PRESS_DB;
          fsm_d.idx = ks_idx;
          fsm_d.cnt = '0;
        end
      end
      PRESS_DB: begin
        if (ks == idx_mask) begin
          if (fsm_q.cnt == CNT_LAST) begin
            accept    = 1'b1;
            fsm_d.st  = HELD;
            fsm_d.cnt = '0;
          end else begin
            fsm_d.cnt = fsm_q.cnt + CNT_W'(1);
          end
        end else begin
          // Bounce, early release or a second key: drop the press silently.
          fsm_d.st  = IDLE;
          fsm_d.cnt = '0;
        end
      end
      HELD: begin
        // No auto-repeat; extra keys while held are ignored until all are up.
        if (ks_zero) begin
          fsm_d.st  = REL_DB;
          fsm_d.cnt = '0;
        end
      end
      REL_DB: begin
        if (ks_zero) begin
          if (fsm_q.cnt == CNT_LAST) begin
            fsm_d.st  = IDLE;
            fsm_d.cnt = '0;
          end else begin
            fsm_d.cnt = fsm_q.cnt + CNT_W'(1);
          end
        end else begin
          // Release bounce goes back to HELD, never through IDLE, so it
          // cannot produce a second pulse.
          fsm_d.st  = HELD;
          fsm_d.cnt = '0;
        end
      end
      default: begin
        fsm_d.st  = IDLE;
        fsm_d.cnt = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q.st  <= IDLE;
      fsm_q.idx <= '0;
      fsm_q.cnt <= '0;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------

  // Pulse outputs are high only in the cycle after acceptance; key_code
  // holds the last accepted key until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_pulse <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_pulse <= accept ? idx_mask : '0;
      key_valid <= accept;
      if (accept) key_code <= fsm_q.idx;
    end
  end

  // busy tracks the state register cycle-for-cycle (registered off the
  // next state so it lines up with the state itself, not a cycle later).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= (fsm_d.st != IDLE);
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: scenario tasks drive key_raw and push expected pulses
// (edge number, one-hot, code) to a scoreboard; a negedge monitor pops and
// compares every pulse the DUT emits.
module tb_keypad_encoder;

  localparam int DB = 4;
  // A key level changed just before edge k is pulsed after edge k+DB+2.
  // Stimulus is applied at the negedge following edge c, so k = c+1.
  localparam int LAT = DB + 3;

  typedef struct {
    int         at;
    logic [11:0] pulse;
    logic [3:0]  code;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [11:0] key_raw;
  logic [11:0] key_pulse;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  keypad_encoder #(.DB_CYC(DB), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .key_pulse (key_pulse),
    .key_valid (key_valid),
    .key_code  (key_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the preceding posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor.
  always @(negedge clk) begin
    checks++;
    if (key_valid !== (|key_pulse)) begin
      errors++;
      $display("FAIL valid_vs_pulse cyc=%0d key_valid=%b key_pulse=%h", cyc, key_valid, key_pulse);
    end
    if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
      checks++; errors++;
      $display("FAIL missing_pulse expected at cyc=%0d pulse=%h, no pulse observed", exp_q[0].at, exp_q[0].pulse);
      void'(exp_q.pop_front());
    end
    if (key_valid === 1'b1 || key_pulse !== 12'h000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d key_pulse=%h key_code=%0d", cyc, key_pulse, key_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc !== e.at || key_pulse !== e.pulse || key_code !== e.code) begin
          errors++;
          $display("FAIL pulse cyc=%0d pulse=%h code=%0d, required cyc=%0d pulse=%h code=%0d",
                   cyc, key_pulse, key_code, e.at, e.pulse, e.code);
        end
      end
    end
  end

  function automatic void push_exp(input int at, input int key);
    exp_t e;
    e.at    = at;
    e.pulse = 12'h001 << key;
    e.code  = 4'(key);
    exp_q.push_back(e);
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Waits for the scoreboard to empty; the monitor retires overdue entries.
  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_raw = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (key_pulse !== 12'h000 || key_valid !== 1'b0 || key_code !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pulse=%h valid=%b code=%0d busy=%b, required all 0",
               key_pulse, key_valid, key_code, busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_press();
    int c;
    @(negedge clk);
    c = cyc;
    key_raw = 12'h020;
    push_exp(c + LAT, 5);
    wait_until(c + 2);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_early busy=%b required 0", busy);
    end
    wait_until(c + 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL single_busy_entry busy=%b required 1", busy);
    end
    wait_until(c + 20);
    key_raw = '0;
    repeat (10) @(negedge clk);
    drain();
  endtask

  task automatic test_press_bounce();
    int c;
    @(negedge clk); key_raw[10] = 1'b1;
    @(negedge clk); key_raw[10] = 1'b0;
    @(negedge clk); key_raw[10] = 1'b1;
    @(negedge clk); key_raw[10] = 1'b0;
    @(negedge clk); key_raw[10] = 1'b1;
    c = cyc;
    push_exp(c + LAT, 10);
    wait_until(c + 12);
    key_raw = '0;
    repeat (10) @(negedge clk);
    drain();
  endtask

  task automatic test_simultaneous();
    int c;
    @(negedge clk);
    key_raw = 12'h003;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL simultaneous_busy cyc=%0d busy=%b required 0", cyc, busy);
      end
    end
    c = cyc;
    key_raw = 12'h001;
    push_exp(c + LAT, 0);
    wait_until(c + 10);
    key_raw = '0;
    repeat (10) @(negedge clk);
    drain();
  endtask

  task automatic test_extra_key();
    int c;
    int d;
    @(negedge clk);
    c = cyc;
    key_raw = 12'h080;
    push_exp(c + LAT, 7);
    wait_until(c + 9);
    key_raw = 12'h088;
    repeat (10) @(negedge clk);
    d = cyc;
    key_raw = '0;
    wait_until(d + DB + 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL extra_busy_before_idle busy=%b required 1", busy);
    end
    wait_until(d + DB + 3);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL extra_busy_idle busy=%b required 0", busy);
    end
    repeat (5) @(negedge clk);
    drain();
    checks++;
    if (key_code !== 4'd7) begin
      errors++; $display("FAIL extra_key_code code=%0d required 7", key_code);
    end
  endtask

  task automatic test_reset_midpress();
    int c;
    int e;
    @(negedge clk);
    c = cyc;
    key_raw = 12'h800;
    wait_until(c + 5);          // PRESS_DB with cnt = 2
    rst = 1'b1;
    #1;
    checks++;
    if (key_pulse !== 12'h000 || key_valid !== 1'b0 || key_code !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midpress_reset pulse=%h valid=%b code=%0d busy=%b, required all 0",
               key_pulse, key_valid, key_code, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    e = cyc;
    push_exp(e + LAT, 11);
    wait_until(e + 10);
    key_raw = '0;
    repeat (10) @(negedge clk);
    drain();
  endtask

  task automatic test_release_bounce();
    int c;
    int d;
    @(negedge clk);
    c = cyc;
    key_raw = 12'h200;
    push_exp(c + LAT, 9);
    wait_until(c + 9);
    key_raw = 12'h000;
    @(negedge clk); key_raw = 12'h200;
    @(negedge clk); key_raw = 12'h000;
    d = cyc;
    wait_until(d + DB + 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL relbounce_busy_before_idle busy=%b required 1", busy);
    end
    wait_until(d + DB + 3);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL relbounce_idle busy=%b required 0", busy);
    end
    repeat (10) @(negedge clk);
    drain();
  endtask

  task automatic test_back_to_back();
    int c;
    int d;
    int e;
    @(negedge clk);
    c = cyc;
    key_raw = 12'h004;
    push_exp(c + LAT, 2);
    wait_until(c + 9);
    d = cyc;
    key_raw = '0;
    wait_until(d + DB + 1);
    e = cyc;
    key_raw = 12'h010;
    push_exp(e + LAT, 4);
    wait_until(e + 9);
    key_raw = '0;
    repeat (10) @(negedge clk);
    drain();
    checks++;
    if (key_code !== 4'd4) begin
      errors++; $display("FAIL b2b_key_code code=%0d required 4", key_code);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_press_bounce();
    test_simultaneous();
    test_extra_key();
    test_reset_midpress();
    test_release_bounce();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d, simulation did not complete", cyc);
    $fatal(1, "watchdog");
  end

endmodule
